// File: rtl/apb_master.sv
// -----------------------------------------------------------------------------
// apb_master
//   APB requester. Takes single read/write commands on a valid/ready port,
//   runs the APB SETUP -> ACCESS sequence (with wait states while pready is
//   low) and returns completion as a one-cycle rsp_valid pulse carrying read
//   data and an error flag. A command may be accepted on the completing edge
//   of the previous transfer, giving one transfer every two cycles.
//
//   Optional feature macro: APB_MASTER_TIMEOUT_EN
//     Defined     : ACCESS aborts after TIMEOUT_CYCLES wait cycles with
//                   rsp_err=1 and returns to IDLE.
//     Not defined : ACCESS waits for pready indefinitely; rsp_err is 0.
//
// Ports
//   clock, resetn            rising-edge clock, async active-low reset
//   cmd_valid/cmd_ready      command handshake (cmd_ready is combinational)
//   cmd_write/addr/wdata     command direction, address and write data
//   rsp_valid/rdata/err      one-cycle response pulse, read data, timeout
//   pselx/penable/pwrite     APB control outputs (registered)
//   paddr/pwdata             APB address / write data (registered)
//   pready/prdata            APB slave ready and read data
// -----------------------------------------------------------------------------
module apb_master #(
  parameter int data_size      = 8,
  parameter int address_size   = 5,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [address_size-1:0] cmd_addr,
  input  logic [data_size-1:0]    cmd_wdata,
  output logic                    rsp_valid,
  output logic [data_size-1:0]    rsp_rdata,
  output logic                    rsp_err,
  output logic                    pselx,
  output logic                    penable,
  output logic                    pwrite,
  output logic [address_size-1:0] paddr,
  output logic [data_size-1:0]    pwdata,
  input  logic                    pready,
  input  logic [data_size-1:0]    prdata
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SETUP  = 2'b01,
    ST_ACCESS = 2'b10
  } state_t;

  state_t                  state_q,     state_d;
  logic                    pselx_q,     pselx_d;
  logic                    penable_q,   penable_d;
  logic                    pwrite_q,    pwrite_d;
  logic [address_size-1:0] paddr_q,     paddr_d;
  logic [data_size-1:0]    pwdata_q,    pwdata_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [data_size-1:0]    rsp_rdata_q, rsp_rdata_d;
  logic                    rsp_err_q,   rsp_err_d;
  logic                    timeout_s;
  logic                    accept_s;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;

  // Fires on the TIMEOUT_CYCLES-th consecutive ACCESS cycle with pready low.
  assign timeout_s = (state_q == ST_ACCESS) && !pready &&
                     (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_s = 1'b0;
`endif

  // A timeout terminal cycle never accepts a new command.
  assign cmd_ready = resetn && !timeout_s &&
                     ((state_q == ST_IDLE) || ((state_q == ST_ACCESS) && pready));
  assign accept_s  = cmd_valid && cmd_ready;

  // Next-state and registered-output computation.
  always_comb begin
    state_d     = state_q;
    pselx_d     = pselx_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
`ifdef APB_MASTER_TIMEOUT_EN
    tmo_cnt_d   = tmo_cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          pwrite_d  = cmd_write;
          paddr_d   = cmd_addr;
          pwdata_d  = cmd_wdata;
          pselx_d   = 1'b1;
          penable_d = 1'b0;
          state_d   = ST_SETUP;
        end else begin
          state_d   = ST_IDLE;
        end
      end
      ST_SETUP: begin
        penable_d = 1'b1;
        state_d   = ST_ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
        tmo_cnt_d = '0;
`endif
      end
      ST_ACCESS: begin
        if (pready) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          if (!pwrite_q) begin
            rsp_rdata_d = prdata;
          end else begin
            rsp_rdata_d = rsp_rdata_q;
          end
          if (accept_s) begin
            // Back-to-back: pselx stays asserted, straight into SETUP.
            pwrite_d  = cmd_write;
            paddr_d   = cmd_addr;
            pwdata_d  = cmd_wdata;
            pselx_d   = 1'b1;
            penable_d = 1'b0;
            state_d   = ST_SETUP;
          end else begin
            pselx_d   = 1'b0;
            penable_d = 1'b0;
            state_d   = ST_IDLE;
          end
        end else if (timeout_s) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          pselx_d     = 1'b0;
          penable_d   = 1'b0;
          state_d     = ST_IDLE;
        end else begin
`ifdef APB_MASTER_TIMEOUT_EN
          tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
`endif
          state_d   = ST_ACCESS;
        end
      end
      default: begin
        // Unused encoding: drop the bus and recover to IDLE.
        pselx_d   = 1'b0;
        penable_d = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      pselx_q     <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pselx_q     <= pselx_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

`ifdef APB_MASTER_TIMEOUT_EN
  // Wait-state counter for the ACCESS timeout.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`endif

  assign pselx     = pselx_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master.sv
// Directed testbench for apb_master with a small 32x8 APB RAM slave model.
module tb_apb_master;

  logic       clock = 1'b0;
  logic       resetn;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_write;
  logic [4:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic       pselx;
  logic       penable;
  logic       pwrite;
  logic [4:0] paddr;
  logic [7:0] pwdata;
  logic       pready;
  logic [7:0] prdata;

  int passed = 0;
  int total  = 0;

  logic [7:0] mem [0:31];

  always #5 clock = ~clock;

  apb_master #(
    .data_size      (8),
    .address_size   (5),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clock     (clock),
    .resetn    (resetn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .pselx     (pselx),
    .penable   (penable),
    .pwrite    (pwrite),
    .paddr     (paddr),
    .pwdata    (pwdata),
    .pready    (pready),
    .prdata    (prdata)
  );

  // Slave RAM: writes on a completed ACCESS, reads combinationally.
  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 32; i++) mem[i] <= 8'h00;
    end else if (pselx && penable && pready && pwrite) begin
      mem[paddr] <= pwdata;
    end
  end
  assign prdata = mem[paddr];

  task automatic test_reset();
    resetn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0;
    cmd_addr = 5'd0; cmd_wdata = 8'h00; pready = 1'b1;
    repeat (2) @(negedge clock);
    total++; if (pselx !== 1'b0) $display("FAIL rst_pselx: got %b exp 0", pselx); else passed++;
    total++; if (penable !== 1'b0) $display("FAIL rst_penable: got %b exp 0", penable); else passed++;
    total++; if (pwrite !== 1'b0) $display("FAIL rst_pwrite: got %b exp 0", pwrite); else passed++;
    total++; if (paddr !== 5'd0) $display("FAIL rst_paddr: got %h exp 0", paddr); else passed++;
    total++; if (pwdata !== 8'h00) $display("FAIL rst_pwdata: got %h exp 0", pwdata); else passed++;
    total++; if (rsp_valid !== 1'b0) $display("FAIL rst_rsp_valid: got %b exp 0", rsp_valid); else passed++;
    total++; if (rsp_rdata !== 8'h00) $display("FAIL rst_rsp_rdata: got %h exp 0", rsp_rdata); else passed++;
    total++; if (rsp_err !== 1'b0) $display("FAIL rst_rsp_err: got %b exp 0", rsp_err); else passed++;
    total++; if (cmd_ready !== 1'b0) $display("FAIL rst_cmd_ready: got %b exp 0", cmd_ready); else passed++;
    resetn = 1'b1;
    #1;
    total++; if (cmd_ready !== 1'b1) $display("FAIL idle_cmd_ready: got %b exp 1", cmd_ready); else passed++;
  endtask

  task automatic test_write();
    @(negedge clock);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 5'd5; cmd_wdata = 8'hA5; pready = 1'b1;
    @(negedge clock);  // SETUP
    cmd_valid = 1'b0; #1;
    total++; if (pselx !== 1'b1 || penable !== 1'b0) $display("FAIL wr_setup: got psel=%b pen=%b exp 1/0", pselx, penable); else passed++;
    total++; if (paddr !== 5'd5 || pwdata !== 8'hA5 || pwrite !== 1'b1) $display("FAIL wr_bus: got a=%h d=%h w=%b exp 05/a5/1", paddr, pwdata, pwrite); else passed++;
    total++; if (cmd_ready !== 1'b0) $display("FAIL wr_setup_ready: got %b exp 0", cmd_ready); else passed++;
    @(negedge clock);  // ACCESS
    total++; if (pselx !== 1'b1 || penable !== 1'b1) $display("FAIL wr_access: got psel=%b pen=%b exp 1/1", pselx, penable); else passed++;
    total++; if (rsp_valid !== 1'b0) $display("FAIL wr_early_rsp: got %b exp 0", rsp_valid); else passed++;
    @(negedge clock);  // response
    total++; if (pselx !== 1'b0 || penable !== 1'b0) $display("FAIL wr_done_bus: got psel=%b pen=%b exp 0/0", pselx, penable); else passed++;
    total++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0) $display("FAIL wr_rsp: got v=%b e=%b exp 1/0", rsp_valid, rsp_err); else passed++;
    total++; if (mem[5] !== 8'hA5) $display("FAIL wr_mem: got %h exp a5", mem[5]); else passed++;
    total++; if (paddr !== 5'd5 || pwrite !== 1'b1) $display("FAIL wr_hold: got a=%h w=%b exp 05/1", paddr, pwrite); else passed++;
    @(negedge clock);
    total++; if (rsp_valid !== 1'b0) $display("FAIL wr_rsp_pulse: got %b exp 0", rsp_valid); else passed++;
  endtask

  task automatic test_read_wait();
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 5'd5; cmd_wdata = 8'h00; pready = 1'b0;
    @(negedge clock);  // SETUP
    cmd_valid = 1'b0;
    total++; if (pselx !== 1'b1 || penable !== 1'b0 || pwrite !== 1'b0) $display("FAIL rd_setup: got psel=%b pen=%b w=%b exp 1/0/0", pselx, penable, pwrite); else passed++;
    @(negedge clock);  // ACCESS, wait 1
    #1;
    total++; if (penable !== 1'b1 || cmd_ready !== 1'b0) $display("FAIL rd_wait1: got pen=%b rdy=%b exp 1/0", penable, cmd_ready); else passed++;
    @(negedge clock);  // wait 2
    total++; if (pselx !== 1'b1 || penable !== 1'b1 || rsp_valid !== 1'b0) $display("FAIL rd_wait2: got psel=%b pen=%b v=%b exp 1/1/0", pselx, penable, rsp_valid); else passed++;
    @(negedge clock);  // still in ACCESS, now release
    total++; if (penable !== 1'b1 || rsp_valid !== 1'b0) $display("FAIL rd_wait3: got pen=%b v=%b exp 1/0", penable, rsp_valid); else passed++;
    pready = 1'b1; #1;
    total++; if (cmd_ready !== 1'b1) $display("FAIL rd_ready_pready: got %b exp 1", cmd_ready); else passed++;
    @(negedge clock);
    total++; if (rsp_valid !== 1'b1 || rsp_rdata !== 8'hA5 || rsp_err !== 1'b0) $display("FAIL rd_rsp: got v=%b d=%h e=%b exp 1/a5/0", rsp_valid, rsp_rdata, rsp_err); else passed++;
    total++; if (pselx !== 1'b0) $display("FAIL rd_done_psel: got %b exp 0", pselx); else passed++;
  endtask

  task automatic test_back_to_back();
    int psel_cycles = 0;
    @(negedge clock);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 5'd1; cmd_wdata = 8'h3C; pready = 1'b1;
    @(negedge clock);  // SETUP of write; present read while held
    psel_cycles += int'(pselx);
    cmd_write = 1'b0; #1;
    total++; if (cmd_ready !== 1'b0) $display("FAIL b2b_setup_ready: got %b exp 0", cmd_ready); else passed++;
    @(negedge clock);  // ACCESS of write
    psel_cycles += int'(pselx);
    total++; if (cmd_ready !== 1'b1 || penable !== 1'b1) $display("FAIL b2b_access: got rdy=%b pen=%b exp 1/1", cmd_ready, penable); else passed++;
    @(negedge clock);  // SETUP of read, write response
    psel_cycles += int'(pselx);
    cmd_valid = 1'b0;
    total++; if (pselx !== 1'b1 || penable !== 1'b0 || pwrite !== 1'b0) $display("FAIL b2b_setup2: got psel=%b pen=%b w=%b exp 1/0/0", pselx, penable, pwrite); else passed++;
    total++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0) $display("FAIL b2b_wr_rsp: got v=%b e=%b exp 1/0", rsp_valid, rsp_err); else passed++;
    @(negedge clock);  // ACCESS of read
    psel_cycles += int'(pselx);
    total++; if (penable !== 1'b1 || rsp_valid !== 1'b0) $display("FAIL b2b_access2: got pen=%b v=%b exp 1/0", penable, rsp_valid); else passed++;
    @(negedge clock);
    total++; if (rsp_valid !== 1'b1 || rsp_rdata !== 8'h3C || pselx !== 1'b0) $display("FAIL b2b_rd_rsp: got v=%b d=%h psel=%b exp 1/3c/0", rsp_valid, rsp_rdata, pselx); else passed++;
    total++; if (psel_cycles !== 4) $display("FAIL b2b_psel_cycles: got %0d exp 4", psel_cycles); else passed++;
  endtask

  task automatic test_reset_in_access();
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 5'd2; cmd_wdata = 8'h77; pready = 1'b0;
    @(negedge clock);  // SETUP
    cmd_valid = 1'b0;
    @(negedge clock);  // ACCESS
    total++; if (penable !== 1'b1) $display("FAIL rsta_in_access: got %b exp 1", penable); else passed++;
    resetn = 1'b0; #1;
    total++; if (pselx !== 1'b0 || penable !== 1'b0) $display("FAIL rsta_async: got psel=%b pen=%b exp 0/0", pselx, penable); else passed++;
    total++; if (cmd_ready !== 1'b0) $display("FAIL rsta_ready: got %b exp 0", cmd_ready); else passed++;
    @(negedge clock);
    resetn = 1'b1; pready = 1'b1;
    @(negedge clock);
    total++; if (rsp_valid !== 1'b0 || pselx !== 1'b0) $display("FAIL rsta_no_rsp: got v=%b psel=%b exp 0/0", rsp_valid, pselx); else passed++;
    total++; if (mem[2] !== 8'h00) $display("FAIL rsta_no_write: got %h exp 00", mem[2]); else passed++;
  endtask

  task automatic test_stall();
    @(negedge clock);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 5'd3; pready = 1'b0;
    @(negedge clock);  // SETUP
    cmd_valid = 1'b0;
    @(negedge clock);  // ACCESS wait 1
`ifdef APB_MASTER_TIMEOUT_EN
    repeat (3) @(negedge clock);  // waits 2..4
    total++; if (penable !== 1'b1 || rsp_valid !== 1'b0) $display("FAIL tmo_before: got pen=%b v=%b exp 1/0", penable, rsp_valid); else passed++;
    #1;
    total++; if (cmd_ready !== 1'b0) $display("FAIL tmo_ready: got %b exp 0", cmd_ready); else passed++;
    @(negedge clock);
    total++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1) $display("FAIL tmo_rsp: got v=%b e=%b exp 1/1", rsp_valid, rsp_err); else passed++;
    total++; if (pselx !== 1'b0 || penable !== 1'b0) $display("FAIL tmo_bus: got psel=%b pen=%b exp 0/0", pselx, penable); else passed++;
    #1;
    total++; if (cmd_ready !== 1'b1) $display("FAIL tmo_idle: got %b exp 1", cmd_ready); else passed++;
    pready = 1'b1;
`else
    begin
      int bad = 0;
      for (int i = 0; i < 100; i++) begin
        @(negedge clock);
        if (pselx !== 1'b1 || penable !== 1'b1 || rsp_valid !== 1'b0 || rsp_err !== 1'b0) bad++;
      end
      total++; if (bad !== 0) $display("FAIL stall_hold: got %0d bad cycles exp 0", bad); else passed++;
    end
    pready = 1'b1;
    @(negedge clock);
    total++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 8'h00) $display("FAIL stall_done: got v=%b e=%b d=%h exp 1/0/00", rsp_valid, rsp_err, rsp_rdata); else passed++;
`endif
    @(negedge clock);
    total++; if (rsp_valid !== 1'b0 || pselx !== 1'b0) $display("FAIL stall_end: got v=%b psel=%b exp 0/0", rsp_valid, pselx); else passed++;
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_wait();
    test_back_to_back();
    test_reset_in_access();
    test_stall();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
